memory_writeback: RTL and testbench
===================================

# memory_writeback

Back end of the MIPS-DLX pipeline: consumes the execution stage results (ALU_out, data_write, WB_register, zero, M_control, WB_control) and closes the loop to instruction decode and fetch. It registers them into an EX/MEM stage, performs the data-memory access, registers into a MEM/WB stage, and drives the register-file write port (busw, rw, reg_write). It also resolves branches from the EX/MEM stage (PC_sel, jump_address).

## Interface
- DATA_WIDTH, 32, data/ALU word width
- ADDR_BITS, 10, data-memory word-address width (2**ADDR_BITS words)
- PC_BITS, 10, program-counter width
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX outputs carry a real instruction (0 = bubble)
- M_control  in  2  [1] mem_write, [0] BOP (branch operation)
- WB_control  in  2  [1] reg_write, [0] mem_to_reg
- zero  in  1  ALU zero flag
- ALU_out  in  DATA_WIDTH  ALU result / memory word address
- data_write  in  DATA_WIDTH  store data
- WB_register  in  5  destination register
- branch_target  in  PC_BITS  taken-branch target computed upstream
- busw  out  DATA_WIDTH  register-file write data
- rw  out  5  register-file write address
- reg_write  out  1  register-file write enable
- PC_sel  out  1  1 = fetch takes jump_address
- jump_address  out  PC_BITS  branch target to fetch
- wb_valid  out  1  MEM/WB holds a real instruction

## Operation
- EX/MEM register captures all inputs on every edge. A bubble (ex_valid=0) is captured with valid=0, and every control bit is forced to 0.
- Data memory: 2**ADDR_BITS x DATA_WIDTH, synchronous, single port. Word address is ALU_out[ADDR_BITS-1:0]; upper bits are ignored, so addresses wrap.
- Store: the memory is written at the edge that ends the MEM cycle when EX/MEM valid and mem_write are both set, and reset=0.
- Read: the memory read is issued every MEM cycle. The read data appears after the same edge, alongside the MEM/WB register.
- MEM/WB register: captures valid, reg_write, mem_to_reg, ALU result and destination register from EX/MEM.
- busw = mem_to_reg ? memory read data : registered ALU result.
- rw = MEM/WB destination register.
- reg_write = MEM/WB valid & reg_write & (rw != 0). Writes to r0 are suppressed.
- PC_sel = EX/MEM valid & BOP & zero (combinational from the EX/MEM register).
- jump_address = EX/MEM branch_target.
- Stores never assert reg_write; branches never write memory. Any control combination is legal and is decoded bit-wise.
- Memory contents are not cleared by reset.

## Timing
- Reset (sampled high at an edge) clears both stage registers. After that edge: busw=0, rw=0, reg_write=0, PC_sel=0, jump_address=0, wb_valid=0.
- Reset has priority over everything. A store pending in EX/MEM when reset is high is dropped, and memory is unchanged.
- Edge E1 captures the EX outputs. PC_sel and jump_address are valid during cycle E1..E2 (1-cycle branch latency).
- Edge E2 performs the memory write/read and captures MEM/WB. busw, rw and reg_write are valid during cycle E2..E3 (2-cycle writeback latency).
- Back-to-back store then load to the same address: the store is written at edge En and the load reads at En+1, so the load returns the new data. No hazard inside the block.
- Full throughput: one instruction per cycle, no stalls, no backpressure.
- Bubble: a bubble propagates with all enables low. busw still shows the datapath value but is ignored.

## Test plan
- Reset: drive reset=1 for 2 cycles with random inputs -> all outputs 0 after the first reset edge; a store presented during reset leaves address 5 at its prior value.
- ALU writeback: ex_valid=1, WB_control=2'b10, ALU_out=32'h0000_1234, WB_register=7 -> two edges later busw=32'h1234, rw=7, reg_write=1, wb_valid=1 for exactly one cycle.
- Store/load: store data_write=32'hDEAD_BEEF at ALU_out=3 (M_control=2'b10), then next cycle load ALU_out=3 (WB_control=2'b11, WB_register=9) -> busw=32'hDEAD_BEEF, rw=9, reg_write=1. Repeat with ALU_out=32'h0000_0403 -> same word (wrap).
- Branch: M_control=2'b01, zero=1, branch_target=10'h2A -> one edge later PC_sel=1, jump_address=10'h2A for one cycle. With zero=0 -> PC_sel=0. With ex_valid=0 -> PC_sel=0.
- r0 suppression: WB_control=2'b10, WB_register=0 -> reg_write stays 0 while wb_valid=1.
- Streaming: 8 consecutive mixed instructions with no gaps -> one writeback per cycle, in order, each exactly 2 edges after its input.

Source files
------------

// File: rtl/memory_writeback.sv
// memory_writeback: EX/MEM stage, data memory, MEM/WB stage and register-file
// write port of the DLX back end. Branches resolve out of EX/MEM (1-cycle
// latency) and writebacks leave MEM/WB (2-cycle latency), one instruction per
// cycle with no stalls.
module memory_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10,
  parameter int PC_BITS    = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [1:0]            M_control,
  input  logic [1:0]            WB_control,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] ALU_out,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic [4:0]            WB_register,
  input  logic [PC_BITS-1:0]    branch_target,
  output logic [DATA_WIDTH-1:0] busw,
  output logic [4:0]            rw,
  output logic                  reg_write,
  output logic                  PC_sel,
  output logic [PC_BITS-1:0]    jump_address,
  output logic                  wb_valid
);

  localparam int MEM_WORDS = 1 << ADDR_BITS;

  // EX/MEM stage
  logic                  r_em_valid;
  logic                  r_em_mem_write;
  logic                  r_em_bop;
  logic                  r_em_reg_write;
  logic                  r_em_mem_to_reg;
  logic                  r_em_zero;
  logic [DATA_WIDTH-1:0] r_em_alu;
  logic [DATA_WIDTH-1:0] r_em_wdata;
  logic [4:0]            r_em_dest;
  logic [PC_BITS-1:0]    r_em_target;

  // MEM/WB stage
  logic                  r_wb_valid;
  logic                  r_wb_reg_write;
  logic                  r_wb_mem_to_reg;
  logic [DATA_WIDTH-1:0] r_wb_alu;
  logic [4:0]            r_wb_dest;

  // Data memory and its registered read port (sits alongside MEM/WB)
  logic [DATA_WIDTH-1:0] r_mem [0:MEM_WORDS-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [ADDR_BITS-1:0]  w_addr;
  logic                  w_store;

  // Upper address bits are dropped so accesses wrap around the memory
  assign w_addr  = r_em_alu[ADDR_BITS-1:0];
  assign w_store = r_em_valid & r_em_mem_write & ~reset;

  // EX/MEM capture: bubbles keep their datapath but carry no enables
  always_ff @(posedge clock) begin
    if (reset) begin
      r_em_valid      <= 1'b0;
      r_em_mem_write  <= 1'b0;
      r_em_bop        <= 1'b0;
      r_em_reg_write  <= 1'b0;
      r_em_mem_to_reg <= 1'b0;
      r_em_zero       <= 1'b0;
      r_em_alu        <= '0;
      r_em_wdata      <= '0;
      r_em_dest       <= '0;
      r_em_target     <= '0;
    end else begin
      r_em_valid      <= ex_valid;
      r_em_mem_write  <= ex_valid & M_control[1];
      r_em_bop        <= ex_valid & M_control[0];
      r_em_reg_write  <= ex_valid & WB_control[1];
      r_em_mem_to_reg <= ex_valid & WB_control[0];
      r_em_zero       <= zero;
      r_em_alu        <= ALU_out;
      r_em_wdata      <= data_write;
      r_em_dest       <= WB_register;
      r_em_target     <= branch_target;
    end
  end

  // MEM/WB capture from EX/MEM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_alu        <= '0;
      r_wb_dest       <= '0;
    end else begin
      r_wb_valid      <= r_em_valid;
      r_wb_reg_write  <= r_em_reg_write;
      r_wb_mem_to_reg <= r_em_mem_to_reg;
      r_wb_alu        <= r_em_alu;
      r_wb_dest       <= r_em_dest;
    end
  end

  // Single-port block RAM: store gated by reset, read every cycle, not cleared
  always_ff @(posedge clock) begin
    if (w_store) begin
      r_mem[w_addr] <= r_em_wdata;
    end
    r_rdata <= r_mem[w_addr];
  end

  // Register-file write port and branch resolution
  assign busw         = r_wb_mem_to_reg ? r_rdata : r_wb_alu;
  assign rw           = r_wb_dest;
  assign reg_write    = r_wb_valid & r_wb_reg_write & (r_wb_dest != 5'd0);
  assign wb_valid     = r_wb_valid;
  assign PC_sel       = r_em_valid & r_em_bop & r_em_zero;
  assign jump_address = r_em_target;

endmodule

// File: tb/tb_memory_writeback.sv
// tb_memory_writeback: directed and randomized checks of memory_writeback
// against a transaction-level model (instruction history plus a memory array).
module tb_memory_writeback;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic [1:0]  M_control;
  logic [1:0]  WB_control;
  logic        zero;
  logic [31:0] ALU_out;
  logic [31:0] data_write;
  logic [4:0]  WB_register;
  logic [9:0]  branch_target;
  logic [31:0] busw;
  logic [4:0]  rw;
  logic        reg_write;
  logic        PC_sel;
  logic [9:0]  jump_address;
  logic        wb_valid;

  memory_writeback #(.DATA_WIDTH(32), .ADDR_BITS(10), .PC_BITS(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .M_control    (M_control),
    .WB_control   (WB_control),
    .zero         (zero),
    .ALU_out      (ALU_out),
    .data_write   (data_write),
    .WB_register  (WB_register),
    .branch_target(branch_target),
    .busw         (busw),
    .rw           (rw),
    .reg_write    (reg_write),
    .PC_sel       (PC_sel),
    .jump_address (jump_address),
    .wb_valid     (wb_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One instruction as the model sees it
  typedef struct {
    bit        valid;
    bit        mw;
    bit        bop;
    bit        rwr;
    bit        m2r;
    bit        zero;
    bit [31:0] alu;
    bit [31:0] wdata;
    bit [4:0]  dest;
    bit [9:0]  tgt;
  } txn_t;

  txn_t      em_m;          // instruction that went in at the previous edge
  bit [31:0] mem_model [1024];
  bit        known [1024];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t null_txn();
    txn_t t;
    t.valid = 0; t.mw = 0; t.bop = 0; t.rwr = 0; t.m2r = 0; t.zero = 0;
    t.alu = 0; t.wdata = 0; t.dest = 0; t.tgt = 0;
    return t;
  endfunction

  // Instruction presented on the inputs; a bubble keeps data, loses enables
  function automatic txn_t from_inputs();
    txn_t t;
    t.valid = ex_valid;
    t.mw    = ex_valid & M_control[1];
    t.bop   = ex_valid & M_control[0];
    t.rwr   = ex_valid & WB_control[1];
    t.m2r   = ex_valid & WB_control[0];
    t.zero  = zero;
    t.alu   = ALU_out;
    t.wdata = data_write;
    t.dest  = WB_register;
    t.tgt   = branch_target;
    return t;
  endfunction

  // Advance one clock and compare every output with the model
  task automatic step();
    txn_t      nx;
    txn_t      wb;
    bit [31:0] rd;
    bit        rd_known;
    int        a;
    nx = reset ? null_txn() : from_inputs();
    wb = reset ? null_txn() : em_m;
    a  = int'(em_m.alu[9:0]);
    rd = mem_model[a];
    rd_known = known[a];
    if (!reset && em_m.valid && em_m.mw) begin
      mem_model[a] = em_m.wdata;
      known[a]     = 1'b1;
    end
    em_m = nx;
    @(posedge clock);
    #1;
    cyc++;
    check_value("pc_sel", {31'd0, PC_sel}, {31'd0, em_m.valid & em_m.bop & em_m.zero});
    check_value("jump_address", {22'd0, jump_address}, {22'd0, em_m.tgt});
    check_value("wb_valid", {31'd0, wb_valid}, {31'd0, wb.valid});
    check_value("rw", {27'd0, rw}, {27'd0, wb.dest});
    check_value("reg_write", {31'd0, reg_write}, {31'd0, wb.valid & wb.rwr & (wb.dest != 5'd0)});
    if (!wb.m2r)
      check_value("busw_alu", busw, wb.alu);
    else if (rd_known)
      check_value("busw_load", busw, rd);
    $display("cyc %0d rst=%0b pc_sel=%0b jump=%h wb_valid=%0b rw=%0d we=%0b busw=%h",
             cyc, reset, PC_sel, jump_address, wb_valid, rw, reg_write, busw);
  endtask

  task automatic drive(input bit v, input bit [1:0] mc, input bit [1:0] wbc, input bit z,
                       input bit [31:0] alu, input bit [31:0] wd, input bit [4:0] dst,
                       input bit [9:0] tgt);
    ex_valid = v; M_control = mc; WB_control = wbc; zero = z;
    ALU_out = alu; data_write = wd; WB_register = dst; branch_target = tgt;
  endtask

  task automatic bubble();
    drive(1'b0, 2'b11, 2'b11, 1'b1, 32'h0000_0077, 32'h0, 5'd3, 10'h3FF);
  endtask

  // Random instruction; a store never also loads, so read/write ordering
  // inside one access never decides the expected value
  task automatic rand_instr();
    bit [1:0]  mc;
    bit [1:0]  wbc;
    bit [31:0] alu;
    mc  = 2'($urandom_range(0, 3));
    wbc = 2'($urandom_range(0, 3));
    if (mc[1]) wbc[0] = 1'b0;
    alu = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
    drive(($urandom_range(0, 7) != 0), mc, wbc, 1'($urandom_range(0, 1)), alu,
          $urandom(), 5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)));
  endtask

  initial begin
    em_m = null_txn();
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = 0;
      known[i]     = 1'b0;
    end

    // Reset with random inputs: everything reads zero
    reset = 1'b1;
    rand_instr();
    step();
    check_value("rst_busw", busw, 32'h0);
    check_value("rst_pc_sel", {31'd0, PC_sel}, 32'd0);
    rand_instr();
    step();
    check_value("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    reset = 1'b0;

    // Seed address 5, then a store to 5 still in EX/MEM when reset arrives
    drive(1'b1, 2'b10, 2'b00, 1'b0, 32'd5, 32'h5555_AAAA, 5'd0, 10'h0);
    step();
    drive(1'b1, 2'b10, 2'b00, 1'b0, 32'd5, 32'h1111_2222, 5'd0, 10'h0);
    step();
    reset = 1'b1;
    rand_instr();
    step();
    rand_instr();
    step();
    reset = 1'b0;
    drive(1'b1, 2'b00, 2'b11, 1'b0, 32'd5, 32'h0, 5'd4, 10'h0);
    step();
    bubble();
    step();
    check_value("rst_store_dropped", busw, 32'h5555_AAAA);

    // ALU writeback, two edges of latency, for exactly one cycle
    drive(1'b1, 2'b00, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 10'h0);
    step();
    bubble();
    step();
    check_value("alu_busw", busw, 32'h0000_1234);
    check_value("alu_rw", {27'd0, rw}, 32'd7);
    check_value("alu_we", {31'd0, reg_write}, 32'd1);
    step();
    check_value("alu_we_once", {31'd0, reg_write}, 32'd0);

    // Store then load the same word, then load via a wrapped address
    drive(1'b1, 2'b10, 2'b00, 1'b0, 32'd3, 32'hDEAD_BEEF, 5'd0, 10'h0);
    step();
    drive(1'b1, 2'b00, 2'b11, 1'b0, 32'd3, 32'h0, 5'd9, 10'h0);
    step();
    drive(1'b1, 2'b00, 2'b11, 1'b0, 32'h0000_0403, 32'h0, 5'd9, 10'h0);
    step();
    check_value("load_busw", busw, 32'hDEAD_BEEF);
    check_value("load_rw", {27'd0, rw}, 32'd9);
    check_value("load_we", {31'd0, reg_write}, 32'd1);
    bubble();
    step();
    check_value("wrap_busw", busw, 32'hDEAD_BEEF);

    // Branch taken, not taken, and bubbled
    drive(1'b1, 2'b01, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0, 10'h2A);
    step();
    check_value("br_taken", {31'd0, PC_sel}, 32'd1);
    check_value("br_target", {22'd0, jump_address}, 32'h2A);
    drive(1'b1, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 10'h2A);
    step();
    check_value("br_not_taken", {31'd0, PC_sel}, 32'd0);
    drive(1'b0, 2'b01, 2'b00, 1'b1, 32'h0, 32'h0, 5'd0, 10'h2A);
    step();
    check_value("br_bubble", {31'd0, PC_sel}, 32'd0);

    // Write to r0 is suppressed while the instruction is still valid
    drive(1'b1, 2'b00, 2'b10, 1'b0, 32'h0000_00AB, 32'h0, 5'd0, 10'h0);
    step();
    bubble();
    step();
    check_value("r0_valid", {31'd0, wb_valid}, 32'd1);
    check_value("r0_we", {31'd0, reg_write}, 32'd0);

    // Back-to-back random stream (first 8 are the gapless streaming case)
    for (int i = 0; i < 400; i++) begin
      rand_instr();
      step();
    end
    bubble();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
